// File: rtl/addr4u_mon_pkg.sv
// Shared types and constants for the 4-bit adder fault monitor.
// Holds the FSM state encoding, datapath widths and settle-time limits.
package addr4u_mon_pkg;

  localparam int unsigned OP_W       = 4;
  localparam int unsigned SUM_W      = 5;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned SETTLE_W   = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StReport = 2'd2
  } state_e;

  // Reference sum, widened so the carry-out is kept.
  function automatic logic [SUM_W-1:0] golden_sum(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
    return SUM_W'(a) + SUM_W'(b);
  endfunction

  // Out-of-range settle times are pinned to the nearest legal value.
  function automatic logic [SETTLE_W-1:0] clamp_settle(input int unsigned cycles);
    if (cycles < SETTLE_MIN) begin
      return SETTLE_W'(SETTLE_MIN);
    end
    if (cycles > SETTLE_MAX) begin
      return SETTLE_W'(SETTLE_MAX);
    end
    return SETTLE_W'(cycles);
  endfunction

endpackage

// File: rtl/addr4u_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Sticks at all-ones instead of wrapping.
module addr4u_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/addr4u_fault_monitor.sv
// Drives operand pairs into an external 4-bit adder, samples its result after a
// settle time and flags/counts mismatches against a golden sum.
module addr4u_fault_monitor
  import addr4u_mon_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   dut_a,
  output logic [OP_W-1:0]   dut_b,
  input  logic [SUM_W-1:0]  dut_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [SUM_W-1:0]  out_golden,
  output logic              out_err,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              sticky_err,
  input  logic              clr_counts
);

  localparam logic [SETTLE_W-1:0] SettleLoad = clamp_settle(SETTLE_CYCLES);

  state_e              state_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                sticky_q;
  logic                res_hs;
  logic                vec_inc;
  logic                err_inc;

  // rst_n gates in_ready so nothing is accepted while reset is held.
  assign in_ready  = rst_n & (state_q == StIdle);
  assign out_valid = (state_q == StReport);
  assign res_hs    = out_valid & out_ready;
  assign vec_inc   = res_hs & ~clr_counts;
  assign err_inc   = vec_inc & out_err;

  // out_golden is loaded at accept; it is only observed once out_valid rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      out_sum    <= '0;
      out_golden <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            dut_a      <= in_a;
            dut_b      <= in_b;
            out_golden <= golden_sum(in_a, in_b);
            settle_q   <= SettleLoad;
            state_q    <= StSettle;
          end
        end
        StSettle: begin
          if (settle_q == SETTLE_W'(1)) begin
            out_sum <= dut_sum;
            out_err <= (dut_sum != out_golden);
            state_q <= StReport;
          end else begin
            settle_q <= settle_q - SETTLE_W'(1);
          end
        end
        StReport: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (clr_counts) begin
      sticky_q <= 1'b0;
    end else if (err_inc) begin
      sticky_q <= 1'b1;
    end
  end

  assign sticky_err = sticky_q;

  addr4u_sat_counter #(
    .CNT_W (CNT_W)
  ) u_vec_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (vec_inc),
    .clr_i   (clr_counts),
    .count_o (vec_count)
  );

  addr4u_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (err_inc),
    .clr_i   (clr_counts),
    .count_o (err_count)
  );

endmodule

// File: tb/tb_addr4u_fault_monitor.sv
// Directed bench: u0 (settle 1, 16-bit counters) runs a vector table and clear case;
// u1 (settle 3, 4-bit counters) covers backpressure, saturation and mid-settle reset.
module tb_addr4u_fault_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rst0_n, in_valid0, in_ready0, out_valid0, out_ready0, out_err0, sticky0, clr0;
  logic       force0;
  logic [3:0] in_a0, in_b0, dut_a0, dut_b0;
  logic [4:0] dut_sum0, out_sum0, out_golden0, force_val0;
  logic [15:0] vec0, errc0;

  logic       rst1_n, in_valid1, in_ready1, out_valid1, out_ready1, out_err1, sticky1, clr1;
  logic       force1;
  logic [3:0] in_a1, in_b1, dut_a1, dut_b1;
  logic [4:0] dut_sum1, out_sum1, out_golden1, force_val1;
  logic [3:0] vec1, errc1;

  // Adder under test: correct unless a fault value is forced.
  assign dut_sum0 = force0 ? force_val0 : {1'b0, dut_a0} + {1'b0, dut_b0};
  assign dut_sum1 = force1 ? force_val1 : {1'b0, dut_a1} + {1'b0, dut_b1};

  addr4u_fault_monitor #(.SETTLE_CYCLES(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst0_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .dut_a(dut_a0), .dut_b(dut_b0), .dut_sum(dut_sum0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_sum(out_sum0),
    .out_golden(out_golden0), .out_err(out_err0), .vec_count(vec0), .err_count(errc0),
    .sticky_err(sticky0), .clr_counts(clr0)
  );

  addr4u_fault_monitor #(.SETTLE_CYCLES(3), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .dut_a(dut_a1), .dut_b(dut_b1), .dut_sum(dut_sum1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_golden(out_golden1), .out_err(out_err1), .vec_count(vec1), .err_count(errc1),
    .sticky_err(sticky1), .clr_counts(clr1)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       fault;
    logic [4:0] fval;
    logic [4:0] sum;
    logic [4:0] golden;
    logic       err;
    int         vec;
    int         errs;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input vec_t v);
    int n;
    n = 0;
    while (!in_ready0 && n < 10) begin step(); n++; end
    check("u0_ready_before", 32'(in_ready0), 1);
    in_a0 = v.a; in_b0 = v.b; force0 = v.fault; force_val0 = v.fval; in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0; in_a0 = 4'h0; in_b0 = 4'h0;
    check("u0_dut_a", 32'(dut_a0), 32'(v.a));
    check("u0_dut_b", 32'(dut_b0), 32'(v.b));
    check("u0_ready_busy", 32'(in_ready0), 0);
    n = 0;
    while (!out_valid0 && n < 20) begin step(); n++; end
    check("u0_latency", 32'(n), 1);
    check("u0_out_sum", 32'(out_sum0), 32'(v.sum));
    check("u0_out_golden", 32'(out_golden0), 32'(v.golden));
    check("u0_out_err", 32'(out_err0), 32'(v.err));
    out_ready0 = 1'b1;
    step();
    out_ready0 = 1'b0; force0 = 1'b0;
    check("u0_vec_count", 32'(vec0), 32'(v.vec));
    check("u0_err_count", 32'(errc0), 32'(v.errs));
    check("u0_valid_after", 32'(out_valid0), 0);
    check("u0_ready_after", 32'(in_ready0), 1);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic fault,
                      input logic [4:0] fval);
    int n;
    n = 0;
    while (!in_ready1 && n < 10) begin step(); n++; end
    in_a1 = a; in_b1 = b; force1 = fault; force_val1 = fval; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin step(); n++; end
    check("u1_latency", 32'(n), 3);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0; force1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [21:0] rst_pack;
    logic [28:0] bp_exp;
    logic        saw;
    vec_t        extra;

    tbl[0] = '{4'hF, 4'h1, 1'b0, 5'h00, 5'h10, 5'h10, 1'b0, 1, 0};
    tbl[1] = '{4'h3, 4'h5, 1'b1, 5'h00, 5'h00, 5'h08, 1'b1, 2, 1};
    tbl[2] = '{4'hF, 4'hF, 1'b0, 5'h00, 5'h1E, 5'h1E, 1'b0, 3, 1};
    tbl[3] = '{4'h0, 4'h0, 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 4, 1};
    tbl[4] = '{4'h7, 4'h8, 1'b1, 5'h1F, 5'h1F, 5'h0F, 1'b1, 5, 2};
    tbl[5] = '{4'hA, 4'h6, 1'b1, 5'h10, 5'h10, 5'h10, 1'b0, 6, 2};

    rst0_n = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; clr0 = 1'b0; force0 = 1'b0;
    in_a0 = 4'h0; in_b0 = 4'h0; force_val0 = 5'h00;
    rst1_n = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; clr1 = 1'b0; force1 = 1'b0;
    in_a1 = 4'h0; in_b1 = 4'h0; force_val1 = 5'h00;

    // Reset held for two cycles.
    step();
    rst_pack = {in_ready0, out_valid0, out_err0, sticky0, dut_a0, dut_b0, out_sum0, out_golden0};
    check("rst_outputs", 32'(rst_pack), 0);
    check("rst_vec_count", 32'(vec0), 0);
    check("rst_err_count", 32'(errc0), 0);
    step();
    check("rst_ready_low", 32'(in_ready0), 0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    step();
    check("ready_after_release", 32'(in_ready0), 1);
    check("u1_ready_after_release", 32'(in_ready1), 1);

    for (int i = 0; i < 6; i++) begin
      run0(tbl[i]);
    end
    check("u0_sticky", 32'(sticky0), 1);

    // Clear coincident with a faulty result handshake.
    in_a0 = 4'h3; in_b0 = 4'h5; force0 = 1'b1; force_val0 = 5'h00; in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    step();
    check("clr_err_seen", 32'(out_err0), 1);
    out_ready0 = 1'b1; clr0 = 1'b1;
    step();
    out_ready0 = 1'b0; clr0 = 1'b0; force0 = 1'b0;
    check("clr_vec_count", 32'(vec0), 0);
    check("clr_err_count", 32'(errc0), 0);
    check("clr_sticky", 32'(sticky0), 0);
    check("clr_idle", 32'(in_ready0), 1);
    check("clr_golden_kept", 32'(out_golden0), 32'h08);
    extra = '{4'h2, 4'h9, 1'b0, 5'h00, 5'h0B, 5'h0B, 1'b0, 1, 0};
    run0(extra);

    // Backpressure on u1.
    in_a1 = 4'h9; in_b1 = 4'h4; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("bp_settle_no_valid", 32'(out_valid1), 0);
      step();
    end
    check("bp_valid_at_settle", 32'(out_valid1), 1);
    bp_exp = {1'b1, 1'b0, 5'h0D, 5'h0D, 1'b0, 4'h9, 4'h4, 4'h0, 4'h0};
    for (int j = 0; j < 5; j++) begin
      in_valid1 = ~j[0]; in_a1 = 4'hF; in_b1 = 4'hF;
      step();
      check("bp_hold", 32'({out_valid1, in_ready1, out_sum1, out_golden1, out_err1,
                            dut_a1, dut_b1, vec1, errc1}), 32'(bp_exp));
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("bp_vec_count", 32'(vec1), 1);
    check("bp_err_count", 32'(errc1), 0);
    check("bp_ready_back", 32'(in_ready1), 1);
    check("bp_dut_a_kept", 32'(dut_a1), 32'h9);

    // Saturation with 4-bit counters.
    for (int i = 0; i < 20; i++) begin
      run1(4'h1, 4'h1, 1'b1, 5'h00);
      check("sat_vec_count", 32'(vec1), (i + 2 > 15) ? 15 : i + 2);
      check("sat_err_count", 32'(errc1), (i + 1 > 15) ? 15 : i + 1);
    end
    check("sat_sticky", 32'(sticky1), 1);

    // Reset while settling discards the transaction.
    in_a1 = 4'h5; in_b1 = 4'h6; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    step();
    rst1_n = 1'b0;
    step();
    check("midrst_valid_low", 32'(out_valid1), 0);
    check("midrst_ready_low", 32'(in_ready1), 0);
    rst1_n = 1'b1;
    saw = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (out_valid1) saw = 1'b1;
      step();
    end
    check("midrst_no_valid", 32'(saw), 0);
    check("midrst_vec_count", 32'(vec1), 0);
    check("midrst_err_count", 32'(errc1), 0);
    check("midrst_sticky", 32'(sticky1), 0);
    check("midrst_idle", 32'(in_ready1), 1);
    check("midrst_dut_a", 32'(dut_a1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
